regfile_write_arbiter: RTL and testbench

Shares the single write port of RegisterFile (WriteRegister/WriteData/RegWrite) between two writeback requesters: A = ALU writeback, B = memory/load writeback. Arbitrates per cycle with valid/ready handshakes and registers the winning write into a one-deep output stage that drives the RegisterFile write port. Also passes the RegisterFile read ports through, with optional forwarding of the pending write.

---
 rtl/rf_arb_pkg.sv | 12 +
 rtl/rr_arbiter2.sv | 41 ++++
 rtl/regfile_write_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared widths, the $zero address and the grant encoding for the register-file
// write arbiter.
package rf_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {GNT_NONE, GNT_A, GNT_B} grantT;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester arbiter: round-robin (PRIORITY_MODE=0) or fixed A-first
// (PRIORITY_MODE=1). It remembers the last requester that actually transferred.
module rr_arbiter2
  import rf_arb_pkg::*;
#(
  parameter int PRIORITY_MODE = 0
) (
  input  logic  Clk,
  input  logic  Reset_n,
  input  logic  Stall,
  input  logic  ValidA,
  input  logic  ValidB,
  output grantT Grant
);

  grantT lastGrant;

  // A grant is a transfer, because it is only issued to a valid requester.
  always_comb begin
    Grant = GNT_NONE;
    if (!Stall) begin
      if (ValidA && ValidB) begin
        Grant = (PRIORITY_MODE == 1 || lastGrant == GNT_B) ? GNT_A : GNT_B;
      end else if (ValidA) begin
        Grant = GNT_A;
      end else if (ValidB) begin
        Grant = GNT_B;
      end
    end
  end

  // Starting from B means A wins the first conflict after reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lastGrant <= GNT_B;
    end else if (Grant != GNT_NONE) begin
      lastGrant <= Grant;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the RegisterFile write port between ALU (A) and load (B) writeback.
// Define RF_WRITE_BYPASS_EN to forward the pending write onto the read data.
module regfile_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int PRIORITY_MODE = 0,
  parameter int CNT_W         = 16
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Stall,
  input  logic                  ReqValidA,
  input  logic [REG_ADDR_W-1:0] ReqRegA,
  input  logic [DATA_W-1:0]     ReqDataA,
  output logic                  ReqReadyA,
  input  logic                  ReqValidB,
  input  logic [REG_ADDR_W-1:0] ReqRegB,
  input  logic [DATA_W-1:0]     ReqDataB,
  output logic                  ReqReadyB,
  output logic [REG_ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0]     WriteData,
  output logic                  RegWrite,
  input  logic [REG_ADDR_W-1:0] ReadRegister1,
  input  logic [REG_ADDR_W-1:0] ReadRegister2,
  input  logic [DATA_W-1:0]     RfReadData1,
  input  logic [DATA_W-1:0]     RfReadData2,
  output logic [DATA_W-1:0]     ReadData1,
  output logic [DATA_W-1:0]     ReadData2,
  output logic [CNT_W-1:0]      ConflictCount
);

  typedef enum logic {IDLE, WRITE} stateT;

  stateT                 state;
  stateT                 stateNext;
  grantT                 grant;
  logic [REG_ADDR_W-1:0] acceptReg;
  logic [DATA_W-1:0]     acceptData;

  rr_arbiter2 #(.PRIORITY_MODE(PRIORITY_MODE)) uArbiter (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Stall   (Stall),
    .ValidA  (ReqValidA),
    .ValidB  (ReqValidB),
    .Grant   (grant)
  );

  assign ReqReadyA  = (grant == GNT_A);
  assign ReqReadyB  = (grant == GNT_B);
  assign acceptReg  = (grant == GNT_B) ? ReqRegB  : ReqRegA;
  assign acceptData = (grant == GNT_B) ? ReqDataB : ReqDataA;

  // Writes to $zero are accepted from the requester but never reach the port.
  always_comb begin
    stateNext = IDLE;
    if (grant != GNT_NONE && acceptReg != ZERO_REG) begin
      stateNext = WRITE;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      WriteRegister <= '0;
      WriteData     <= '0;
    end else if (stateNext == WRITE) begin
      WriteRegister <= acceptReg;
      WriteData     <= acceptData;
    end
  end

  assign RegWrite = (state == WRITE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ConflictCount <= '0;
    end else if (ReqValidA && ReqValidB && !Stall && ConflictCount != '1) begin
      ConflictCount <= ConflictCount + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef RF_WRITE_BYPASS_EN
  // The write sitting on the port commits only at the next edge, so readers see it here first.
  always_comb begin
    ReadData1 = RfReadData1;
    ReadData2 = RfReadData2;
    if (RegWrite && WriteRegister == ReadRegister1 && ReadRegister1 != ZERO_REG) begin
      ReadData1 = WriteData;
    end
    if (RegWrite && WriteRegister == ReadRegister2 && ReadRegister2 != ZERO_REG) begin
      ReadData2 = WriteData;
    end
  end
`else
  logic unusedReadAddr;
  assign unusedReadAddr = ^{ReadRegister1, ReadRegister2};
  assign ReadData1      = RfReadData1;
  assign ReadData2      = RfReadData2;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed literal checks followed by random
// traffic compared every cycle against a behavioural model.
module tb_regfile_write_arbiter;

  localparam int TB_CNT_W = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          Stall;
  logic          ReqValidA, ReqValidB;
  logic [4:0]    ReqRegA, ReqRegB;
  logic [31:0]   ReqDataA, ReqDataB;
  logic          ReqReadyA, ReqReadyB;
  logic [4:0]    WriteRegister;
  logic [31:0]   WriteData;
  logic          RegWrite;
  logic [4:0]    ReadRegister1, ReadRegister2;
  logic [31:0]   RfReadData1, RfReadData2;
  logic [31:0]   ReadData1, ReadData2;
  logic [TB_CNT_W-1:0] ConflictCount;

  logic          p1ReadyA, p1ReadyB, p1RegWrite;
  logic [4:0]    p1WriteRegister;
  logic [31:0]   p1WriteData, p1ReadData1, p1ReadData2;
  logic [TB_CNT_W-1:0] p1ConflictCount;

  int compared   = 0;
  int mismatched = 0;
  bit checkEn    = 1'b0;

  always #5 Clk = ~Clk;

  regfile_write_arbiter #(.PRIORITY_MODE(0), .CNT_W(TB_CNT_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Stall(Stall),
    .ReqValidA(ReqValidA), .ReqRegA(ReqRegA), .ReqDataA(ReqDataA), .ReqReadyA(ReqReadyA),
    .ReqValidB(ReqValidB), .ReqRegB(ReqRegB), .ReqDataB(ReqDataB), .ReqReadyB(ReqReadyB),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .RfReadData1(RfReadData1), .RfReadData2(RfReadData2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .ConflictCount(ConflictCount)
  );

  regfile_write_arbiter #(.PRIORITY_MODE(1), .CNT_W(TB_CNT_W)) dutFixed (
    .Clk(Clk), .Reset_n(Reset_n), .Stall(Stall),
    .ReqValidA(ReqValidA), .ReqRegA(ReqRegA), .ReqDataA(ReqDataA), .ReqReadyA(p1ReadyA),
    .ReqValidB(ReqValidB), .ReqRegB(ReqRegB), .ReqDataB(ReqDataB), .ReqReadyB(p1ReadyB),
    .WriteRegister(p1WriteRegister), .WriteData(p1WriteData), .RegWrite(p1RegWrite),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .RfReadData1(RfReadData1), .RfReadData2(RfReadData2),
    .ReadData1(p1ReadData1), .ReadData2(p1ReadData2), .ConflictCount(p1ConflictCount)
  );

  // Behavioural model of the round-robin instance.
  bit          mLastWasA;
  bit          mRegWrite;
  logic [4:0]  mReg;
  logic [31:0] mData;
  int          mConflict;
  bit          mAccA, mAccB;

  function automatic void expReady(output bit ra, output bit rb);
    ra = 1'b0;
    rb = 1'b0;
    if (!Stall) begin
      if (ReqValidA && ReqValidB) begin
        ra = !mLastWasA;
        rb = mLastWasA;
      end else begin
        ra = ReqValidA;
        rb = ReqValidB;
      end
    end
  endfunction

  function automatic logic [31:0] expRead(input logic [4:0] rr, input logic [31:0] rf);
`ifdef RF_WRITE_BYPASS_EN
    if (mRegWrite && mReg == rr && rr != 5'd0) return mData;
`endif
    return rf;
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    bit ra, rb;
    if (!Reset_n) begin
      mLastWasA <= 1'b0;
      mRegWrite <= 1'b0;
      mReg      <= 5'd0;
      mData     <= 32'd0;
      mConflict <= 0;
      mAccA     <= 1'b0;
      mAccB     <= 1'b0;
    end else begin
      expReady(ra, rb);
      mAccA <= ra;
      mAccB <= rb;
      if (ra) begin
        mLastWasA <= 1'b1;
        mRegWrite <= (ReqRegA != 5'd0);
        mReg      <= ReqRegA;
        mData     <= ReqDataA;
      end else if (rb) begin
        mLastWasA <= 1'b0;
        mRegWrite <= (ReqRegB != 5'd0);
        mReg      <= ReqRegB;
        mData     <= ReqDataB;
      end else begin
        mRegWrite <= 1'b0;
      end
      if (ReqValidA && ReqValidB && !Stall && mConflict < CNT_MAX) mConflict <= mConflict + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model comparison on every falling edge while the bench is not mid-reset.
  always @(negedge Clk) begin
    bit ra, rb;
    if (checkEn) begin
      expReady(ra, rb);
      checkOutput("ReqReadyA", 32'(ReqReadyA), 32'(ra));
      checkOutput("ReqReadyB", 32'(ReqReadyB), 32'(rb));
      checkOutput("RegWrite", 32'(RegWrite), 32'(mRegWrite));
      if (mRegWrite) begin
        checkOutput("WriteRegister", 32'(WriteRegister), 32'(mReg));
        checkOutput("WriteData", WriteData, mData);
      end
      checkOutput("ConflictCount", 32'(ConflictCount), 32'(mConflict));
      checkOutput("ReadData1", ReadData1, expRead(ReadRegister1, RfReadData1));
      checkOutput("ReadData2", ReadData2, expRead(ReadRegister2, RfReadData2));
    end
  end

  task automatic applyDirected(input bit va, input logic [4:0] ra, input logic [31:0] da,
                               input bit vb, input logic [4:0] rb, input logic [31:0] db,
                               input bit st);
    @(posedge Clk);
    #1;
    ReqValidA = va; ReqRegA = ra; ReqDataA = da;
    ReqValidB = vb; ReqRegB = rb; ReqDataB = db;
    Stall = st;
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
    RfReadData1 = 32'd0;  RfReadData2 = 32'd0;
  endtask

  // Requesters only change their request once the model says it was accepted.
  task automatic applyStimulus();
    @(posedge Clk);
    #1;
    if (!ReqValidA || mAccA) begin
      ReqValidA = 1'($urandom_range(0, 1));
      ReqRegA   = 5'($urandom_range(0, 7));
      ReqDataA  = $urandom;
    end
    if (!ReqValidB || mAccB) begin
      ReqValidB = 1'($urandom_range(0, 1));
      ReqRegB   = 5'($urandom_range(0, 7));
      ReqDataB  = $urandom;
    end
    Stall         = ($urandom_range(0, 7) == 0);
    ReadRegister1 = 5'($urandom_range(0, 7));
    ReadRegister2 = 5'($urandom_range(0, 7));
    RfReadData1   = $urandom;
    RfReadData2   = $urandom;
  endtask

  initial begin
    Reset_n = 1'b0;
    Stall = 1'b0;
    ReqValidA = 1'b0; ReqRegA = 5'd0; ReqDataA = 32'd0;
    ReqValidB = 1'b0; ReqRegB = 5'd0; ReqDataB = 32'd0;
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
    RfReadData1 = 32'd0;  RfReadData2 = 32'd0;

    #2;
    checkOutput("resetRegWrite", 32'(RegWrite), 32'd0);
    checkOutput("resetWriteRegister", 32'(WriteRegister), 32'd0);
    checkOutput("resetWriteData", WriteData, 32'd0);
    checkOutput("resetConflictCount", 32'(ConflictCount), 32'd0);
    #10;
    Reset_n = 1'b1;
    checkEn = 1'b1;

    // A alone
    applyDirected(1'b1, 5'b11010, 32'h8000007F, 1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge Clk);
    checkOutput("aOnlyReadyA", 32'(ReqReadyA), 32'd1);
    applyDirected(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge Clk);
    checkOutput("aOnlyRegWrite", 32'(RegWrite), 32'd1);
    checkOutput("aOnlyWriteRegister", 32'(WriteRegister), 32'd26);
    checkOutput("aOnlyWriteData", WriteData, 32'h8000007F);

    // Reset asserted while a write is on the port
    checkEn = 1'b0;
    #1 Reset_n = 1'b0;
    #1;
    checkOutput("midResetRegWrite", 32'(RegWrite), 32'd0);
    checkOutput("midResetWriteRegister", 32'(WriteRegister), 32'd0);
    checkOutput("midResetWriteData", WriteData, 32'd0);
    checkOutput("midResetConflictCount", 32'(ConflictCount), 32'd0);
    @(posedge Clk);
    #2 Reset_n = 1'b1;
    checkEn = 1'b1;

    // Four-cycle conflict, both to register 3
    for (int i = 0; i < 4; i++) begin
      applyDirected(1'b1, 5'd3, 32'hAAAA0001, 1'b1, 5'd3, 32'hBBBB0002, 1'b0);
      @(negedge Clk);
      checkOutput("rrReadyA", 32'(ReqReadyA), 32'((i % 2) == 0));
      checkOutput("rrReadyB", 32'(ReqReadyB), 32'((i % 2) == 1));
      checkOutput("fixedReadyA", 32'(p1ReadyA), 32'd1);
      checkOutput("fixedReadyB", 32'(p1ReadyB), 32'd0);
    end
    applyDirected(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge Clk);
    checkOutput("conflictCount4", 32'(ConflictCount), 32'd4);
    checkOutput("lastWinnerData", WriteData, 32'hBBBB0002);

    // B writes $zero
    applyDirected(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000DEAD, 1'b0);
    @(negedge Clk);
    checkOutput("zeroRegReadyB", 32'(ReqReadyB), 32'd1);
    applyDirected(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge Clk);
    checkOutput("zeroRegRegWrite", 32'(RegWrite), 32'd0);

    // Stall with both valid
    applyDirected(1'b1, 5'd5, 32'h00005555, 1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge Clk);
    applyDirected(1'b1, 5'd6, 32'h00006666, 1'b1, 5'd7, 32'h00007777, 1'b1);
    @(negedge Clk);
    checkOutput("stallReadyA", 32'(ReqReadyA), 32'd0);
    checkOutput("stallReadyB", 32'(ReqReadyB), 32'd0);
    checkOutput("stallInFlight", 32'(RegWrite), 32'd1);
    applyDirected(1'b1, 5'd6, 32'h00006666, 1'b1, 5'd7, 32'h00007777, 1'b1);
    @(negedge Clk);
    checkOutput("stallRegWrite", 32'(RegWrite), 32'd0);
    checkOutput("stallConflictCount", 32'(ConflictCount), 32'd4);

    // Read while register 19 is pending
    applyDirected(1'b1, 5'd19, 32'h12345678, 1'b0, 5'd0, 32'd0, 1'b0);
    applyDirected(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    ReadRegister1 = 5'd19;
    ReadRegister2 = 5'd19;
    @(negedge Clk);
`ifdef RF_WRITE_BYPASS_EN
    checkOutput("bypassReadData1", ReadData1, 32'h12345678);
`else
    checkOutput("bypassReadData1", ReadData1, 32'd0);
`endif

    applyDirected(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
    end

    @(negedge Clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
